omem_port_arbiter: RTL and testbench

- Owns the single OMEM port (EN_O/RW_O/ADDR_O/WDATA_O, RDATA_O).
- Arbitrates the port between two requesters:
  - the output-stage store stream: plain writes, or accumulating read-modify-writes;
  - a host readout requester.
- Store requests are buffered in a small FIFO with ready backpressure.
- Accumulates are serialised as a read cycle then a write cycle with 4-lane signed 16-bit add.
- Sits between OutputStage/OMBuffer and OMEM, replacing the ad-hoc OMSRC mux.

---
 rtl/macarray_pkg.sv | 25 ++
 rtl/omem_store_fifo.sv | 56 +++++
 rtl/omem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_omem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macarray_pkg.sv
// Shared types and lane arithmetic for the OMEM port arbiter.
package macarray_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int OM_AW  = 4;
  localparam int OM_DW  = LANES * LANE_W;

  typedef enum logic {S_IDLE, S_ACC_WR} state_t;

  typedef struct packed {
    logic             acc;
    logic [OM_AW-1:0] addr;
    logic [OM_DW-1:0] data;
  } store_entry_t;

  // Per-lane signed add; each lane wraps independently at 16 bits.
  function automatic logic [OM_DW-1:0] lane_add(input logic [OM_DW-1:0] a,
                                                input logic [OM_DW-1:0] b);
    logic [OM_DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
    return r;
  endfunction
endpackage

// File: rtl/omem_store_fifo.sv
// DEPTH-entry synchronous store FIFO with a flush that also drops a same-cycle push.
module omem_store_fifo
  import macarray_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = store_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign head    = mem[rd_ptr];

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/omem_port_arbiter.sv
// Single OMEM port owner: arbitrates buffered stores/RMW accumulates against host reads.
module omem_port_arbiter
  import macarray_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 4,
  parameter int AW         = 4,
  parameter int DW         = 64
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CLR,
  input  logic          VLD_S,
  output logic          RDY_S,
  input  logic          ACC_S,
  input  logic [AW-1:0] ADDR_S,
  input  logic [DW-1:0] DATA_S,
  input  logic          REQ_H,
  input  logic [AW-1:0] ADDR_H,
  output logic          GNT_H,
  output logic          VALID_H,
  output logic [DW-1:0] RDATA_H,
  output logic          EN_O,
  output logic          RW_O,
  output logic [AW-1:0] ADDR_O,
  output logic [DW-1:0] WDATA_O,
  input  logic [DW-1:0] RDATA_O,
  output logic          IDLE
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef struct packed {
    logic          acc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } store_t;

  state_t                 state, state_nxt;
  logic [SW-1:0]          starve, starve_nxt;
  logic [AW-1:0]          hold_addr;
  logic [DW-1:0]          hold_data;
  logic                   hold_ld, fifo_pop, fifo_full, fifo_empty, store_avail;
  logic [$clog2(DEPTH):0] fifo_count;
  store_t                 fifo_din, head;
  logic                   valid_h;

  assign fifo_din = '{acc: ACC_S, addr: ADDR_S, data: DATA_S};

  omem_store_fifo #(.DEPTH(DEPTH), .entry_t(store_t)) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .clr   (CLR),
    .push  (VLD_S && RDY_S),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign RDY_S       = !fifo_full;
  // A flush cycle issues no queued store, so the flushed entries never reach OMEM.
  assign store_avail = !fifo_empty && !CLR;

  // Port decode is gated by RSTN so the port goes quiet as soon as reset asserts.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    hold_ld    = 1'b0;
    fifo_pop   = 1'b0;
    EN_O       = 1'b0;
    RW_O       = 1'b0;
    ADDR_O     = '0;
    WDATA_O    = '0;
    GNT_H      = 1'b0;
    if (RSTN) begin
      case (state)
        S_IDLE: begin
          if (REQ_H && (!store_avail || starve == STARVE_MAX)) begin
            EN_O       = 1'b1;
            ADDR_O     = ADDR_H;
            GNT_H      = 1'b1;
            starve_nxt = '0;
          end else if (store_avail) begin
            EN_O     = 1'b1;
            ADDR_O   = head.addr;
            fifo_pop = 1'b1;
            if (REQ_H && starve != STARVE_MAX) starve_nxt = starve + 1'b1;
            if (head.acc) begin
              hold_ld   = 1'b1;
              state_nxt = S_ACC_WR;
            end else begin
              RW_O    = 1'b1;
              WDATA_O = head.data;
            end
          end
        end
        S_ACC_WR: begin
          EN_O      = 1'b1;
          RW_O      = 1'b1;
          ADDR_O    = hold_addr;
          WDATA_O   = lane_add(RDATA_O, hold_data);
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
      if (CLR) starve_nxt = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      starve    <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      valid_h   <= 1'b0;
    end else begin
      state   <= state_nxt;
      starve  <= starve_nxt;
      valid_h <= GNT_H;
      if (hold_ld) begin
        hold_addr <= head.addr;
        hold_data <= head.data;
      end
    end
  end

  assign VALID_H = valid_h;
  assign RDATA_H = valid_h ? RDATA_O : '0;
  assign IDLE    = (fifo_count == '0) && (state == S_IDLE) && !valid_h;
endmodule

// File: tb/tb_omem_port_arbiter.sv
// Directed bench with a queue-level reference model checked every cycle.
module tb_omem_port_arbiter;
  logic        CLK, RSTN, CLR, VLD_S, RDY_S, ACC_S, REQ_H, GNT_H, VALID_H;
  logic        EN_O, RW_O, IDLE;
  logic [3:0]  ADDR_S, ADDR_H, ADDR_O;
  logic [63:0] DATA_S, RDATA_H, WDATA_O, RDATA_O;

  int checks = 0;
  int failures = 0;
  bit saw_full = 0;

  omem_port_arbiter dut (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .VLD_S(VLD_S), .RDY_S(RDY_S),
    .ACC_S(ACC_S), .ADDR_S(ADDR_S), .DATA_S(DATA_S), .REQ_H(REQ_H),
    .ADDR_H(ADDR_H), .GNT_H(GNT_H), .VALID_H(VALID_H), .RDATA_H(RDATA_H),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
    .RDATA_O(RDATA_O), .IDLE(IDLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // OMEM behavioural memory: one-cycle read latency.
  logic [63:0] omem [16];
  initial begin
    for (int i = 0; i < 16; i++) omem[i] <= 64'h0;
    omem[5] <= 64'h7FFF_0001_FFFF_0010;
    omem[7] <= 64'hCAFE_1234_5678_9ABC;
    RDATA_O <= 64'h0;
  end
  always @(posedge CLK) begin
    if (EN_O) begin
      if (RW_O) omem[ADDR_O] <= WDATA_O;
      else      RDATA_O <= omem[ADDR_O];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ladd(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [15:0] s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = a[16*i +: 16] + b[16*i +: 16];
      r[16*i +: 16] = s;
    end
    return r;
  endfunction

  // Reference model: a store queue, a pending-RMW slot, a starvation count.
  typedef struct {
    bit          acc;
    logic [3:0]  addr;
    logic [63:0] data;
  } st_t;
  st_t         q[$];
  int          starve = 0;
  bit          rmw = 0;
  logic [3:0]  h_addr;
  logic [63:0] h_data;
  bit          m_vh = 0;
  logic [63:0] m_rdh = 64'h0;

  always @(negedge CLK) begin
    bit          e_en, e_rw, e_gnt, e_rdy, e_idle, avail, nx_vh;
    logic [3:0]  e_addr;
    logic [63:0] e_wd, e_rdh, nx_rdh;
    st_t         h;
    e_en = 0; e_rw = 0; e_gnt = 0; e_addr = '0; e_wd = '0; nx_vh = 0; nx_rdh = '0;
    if (RSTN && !RDY_S) saw_full = 1;
    if (!RSTN) begin
      q.delete(); starve = 0; rmw = 0; m_vh = 0; m_rdh = '0;
      chk("rst_en", EN_O, 0);       chk("rst_rw", RW_O, 0);
      chk("rst_addr", ADDR_O, 0);   chk("rst_wdata", WDATA_O, 0);
      chk("rst_gnt", GNT_H, 0);     chk("rst_valid", VALID_H, 0);
      chk("rst_rdata_h", RDATA_H, 0);
      chk("rst_rdy", RDY_S, 1);     chk("rst_idle", IDLE, 1);
    end else begin
      e_rdy  = q.size() < 4;
      e_idle = (q.size() == 0) && !rmw && !m_vh;
      e_rdh  = m_vh ? m_rdh : 64'h0;
      avail  = (q.size() > 0) && !CLR;
      if (rmw) begin
        e_en = 1; e_rw = 1; e_addr = h_addr; e_wd = ladd(omem[h_addr], h_data); rmw = 0;
      end else if (REQ_H && (!avail || starve == 4)) begin
        e_en = 1; e_gnt = 1; e_addr = ADDR_H; starve = 0;
        nx_vh = 1; nx_rdh = omem[ADDR_H];
      end else if (avail) begin
        h = q.pop_front();
        e_en = 1; e_addr = h.addr;
        if (REQ_H && starve < 4) starve++;
        if (h.acc) begin
          rmw = 1; h_addr = h.addr; h_data = h.data;
        end else begin
          e_rw = 1; e_wd = h.data;
        end
      end
      chk("m_en", EN_O, e_en);
      if (e_en) begin
        chk("m_rw", RW_O, e_rw);
        chk("m_addr", ADDR_O, e_addr);
        if (e_rw) chk("m_wdata", WDATA_O, e_wd);
      end
      chk("m_gnt", GNT_H, e_gnt);
      chk("m_valid", VALID_H, m_vh);
      chk("m_rdata_h", RDATA_H, e_rdh);
      chk("m_rdy", RDY_S, e_rdy);
      chk("m_idle", IDLE, e_idle);
      if (CLR) begin
        q.delete(); starve = 0;
      end else if (VLD_S && e_rdy) begin
        q.push_back('{acc: ACC_S, addr: ADDR_S, data: DATA_S});
      end
      m_vh = nx_vh; m_rdh = nx_rdh;
    end
  end

  task automatic push(input bit acc, input logic [3:0] a, input logic [63:0] d);
    int n;
    bit done;
    n = 0; done = 0;
    VLD_S = 1; ACC_S = acc; ADDR_S = a; DATA_S = d;
    while (!done) begin
      @(negedge CLK);
      done = RDY_S;
      n++;
      @(posedge CLK); #1;
      if (!done && n > 50) begin
        chk("push_timeout", RDY_S, 1);
        done = 1;
      end
    end
    VLD_S = 0; ACC_S = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge CLK);
    while (!IDLE && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_idle", IDLE, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1);
  end

  initial begin
    RSTN = 0; CLR = 0; VLD_S = 0; ACC_S = 0; ADDR_S = '0; DATA_S = '0;
    REQ_H = 0; ADDR_H = '0;
    repeat (2) @(negedge CLK);
    chk("reset_rdy", RDY_S, 1);
    chk("reset_idle", IDLE, 1);
    chk("reset_en", EN_O, 0);
    @(posedge CLK); #1;
    RSTN = 1;
    @(posedge CLK); #1;

    // Plain store: issued the cycle after acceptance.
    push(0, 4'd3, 64'h0004_0003_0002_0001);
    @(negedge CLK);
    chk("plain_en", EN_O, 1);
    chk("plain_rw", RW_O, 1);
    chk("plain_addr", ADDR_O, 3);
    chk("plain_wdata", WDATA_O, 64'h0004_0003_0002_0001);
    @(negedge CLK);
    chk("plain_idle_after", IDLE, 1);
    @(posedge CLK); #1;

    // Accumulate with per-lane wrap.
    push(1, 4'd5, 64'h0001_0001_0001_0010);
    @(negedge CLK);
    chk("acc_rd_en", EN_O, 1);
    chk("acc_rd_rw", RW_O, 0);
    chk("acc_rd_addr", ADDR_O, 5);
    @(negedge CLK);
    chk("acc_wr_rw", RW_O, 1);
    chk("acc_wr_addr", ADDR_O, 5);
    chk("acc_wr_wdata", WDATA_O, 64'h8000_0002_0000_0020);
    wait_idle(20);
    chk("acc_mem5", omem[5], 64'h8000_0002_0000_0020);
    @(posedge CLK); #1;

    // Back-to-back RMWs to one address, then more RMWs to fill the FIFO.
    push(1, 4'd2, 64'h0001_0001_0001_0001);
    push(1, 4'd2, 64'h0001_0001_0001_0001);
    for (int k = 0; k < 5; k++) push(1, 4'd12, 64'h0001_0001_0001_0001);
    wait_idle(100);
    chk("b2b_mem2", omem[2], 64'h0002_0002_0002_0002);
    chk("b2b_mem12", omem[12], 64'h0005_0005_0005_0005);
    chk("b2b_rdy_low_seen", saw_full, 1);
    @(posedge CLK); #1;

    // Starvation: host read wins after four store grants.
    fork
      begin
        for (int k = 0; k < 8; k++)
          push(0, 4'(8 + k), 64'(k + 1) * 64'h0001_0001_0001_0001);
      end
      begin
        int n, stores;
        bit got;
        n = 0; stores = 0; got = 0;
        @(posedge CLK); #1;
        REQ_H = 1; ADDR_H = 4'd7;
        while (!got && n < 30) begin
          @(negedge CLK);
          if (GNT_H) got = 1;
          else if (EN_O && RW_O) stores++;
          n++;
        end
        chk("starve_gnt_seen", got, 1);
        chk("starve_store_grants", stores, 4);
        @(posedge CLK); #1;
        REQ_H = 0;
        @(negedge CLK);
        chk("starve_valid_h", VALID_H, 1);
        chk("starve_rdata_h", RDATA_H, 64'hCAFE_1234_5678_9ABC);
      end
    join
    wait_idle(50);
    chk("starve_mem15", omem[15], 64'h0008_0008_0008_0008);
    @(posedge CLK); #1;

    // CLR during the RMW write with three entries queued behind it.
    for (int k = 0; k < 3; k++) push(1, 4'd4, 64'h0001_0001_0001_0001);
    for (int k = 0; k < 3; k++) push(1, 4'd6, 64'h0001_0001_0001_0001);
    CLR = 1;
    @(negedge CLK);
    chk("clr_wr_en", EN_O, 1);
    chk("clr_wr_rw", RW_O, 1);
    chk("clr_wr_addr", ADDR_O, 4);
    @(posedge CLK); #1;
    CLR = 0;
    @(negedge CLK);
    chk("clr_after_en", EN_O, 0);
    chk("clr_after_idle", IDLE, 1);
    repeat (4) @(negedge CLK);
    chk("clr_mem4", omem[4], 64'h0003_0003_0003_0003);
    chk("clr_mem6", omem[6], 64'h0);
    @(posedge CLK); #1;

    // Reset asserted in the middle of the RMW write cycle.
    push(1, 4'd1, 64'h0001_0001_0001_0001);
    @(posedge CLK); #1;
    chk("rstmid_pre_en", EN_O, 1);
    chk("rstmid_pre_rw", RW_O, 1);
    #1;
    RSTN = 0; REQ_H = 1; ADDR_H = 4'd7;
    #1;
    chk("rstmid_en", EN_O, 0);
    chk("rstmid_gnt", GNT_H, 0);
    chk("rstmid_valid", VALID_H, 0);
    @(negedge CLK);
    @(posedge CLK); #1;
    REQ_H = 0;
    @(posedge CLK); #1;
    RSTN = 1;
    @(negedge CLK);
    chk("rstmid_rdy", RDY_S, 1);
    chk("rstmid_idle", IDLE, 1);
    chk("rstmid_mem1", omem[1], 64'h0);
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
